// File: rtl/matmul_job_sched.sv
// Job scheduler that shares one matmul engine among NUM_REQ requesters:
// round-robin grant, descriptor load, start pulse, write-count check, timeout abort, response.
module matmul_job_sched #(
  parameter int NUM_REQ         = 4,
  parameter int ID_W            = 2,
  parameter int ADDR_W          = 16,
  parameter int DIM_INDEX_WIDTH = 3,
  parameter int TIMEOUT_CYCLES  = 4095
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_a_base,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_b_base,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_c_base,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic                           rsp_err,
  output logic                           eng_start,
  output logic                           eng_abort,
  output logic [ADDR_W-1:0]              eng_a_base,
  output logic [ADDR_W-1:0]              eng_b_base,
  output logic [ADDR_W-1:0]              eng_c_base,
  input  logic                           eng_res_write_en,
  input  logic                           eng_exec_done,
  output logic                           busy,
  output logic [ID_W-1:0]                owner_id
);

  localparam int CNT_W      = 2 * DIM_INDEX_WIDTH + 1;
  localparam int EXP_WRITES = 1 << (2 * DIM_INDEX_WIDTH);
  localparam int TMR_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_owner;
  logic [CNT_W-1:0]    r_cnt;
  logic [TMR_W-1:0]    r_timer;
  logic                r_err;
  logic [ADDR_W-1:0]   r_a_base;
  logic [ADDR_W-1:0]   r_b_base;
  logic [ADDR_W-1:0]   r_c_base;

  logic                w_found;
  logic [ID_W-1:0]     w_winner;
  logic [NUM_REQ-1:0]  w_owner_oh;
  logic                w_timeout;
  logic                w_rsp_hs;
  logic [CNT_W:0]      w_sum;
  logic                w_count_ok;

  // Requester index reached by stepping k places up from p, wrapping modulo NUM_REQ.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] p, input int k);
    return ID_W'((int'(p) + k) % NUM_REQ);
  endfunction

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[rr_idx(r_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = rr_idx(r_ptr, k);
      end
    end
  end

  assign w_owner_oh = NUM_REQ'(1) << r_owner;
  assign w_timeout  = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign w_rsp_hs   = rsp_ready[r_owner];
  // A write landing in the same cycle as done still belongs to this job.
  assign w_sum      = {1'b0, r_cnt} + (CNT_W + 1)'(eng_res_write_en);
  assign w_count_ok = (w_sum == (CNT_W + 1)'(EXP_WRITES));

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    rsp_valid    = '0;
    eng_start    = 1'b0;
    eng_abort    = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          req_ready    = NUM_REQ'(1) << w_winner;
          w_state_next = S_START;
        end
      end
      S_START: begin
        eng_start    = 1'b1;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        if (eng_exec_done) begin
          w_state_next = S_RESP;
        end else if (w_timeout) begin
          eng_abort    = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = w_owner_oh;
        if (w_rsp_hs) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
      r_timer  <= '0;
      r_err    <= 1'b0;
      r_a_base <= '0;
      r_b_base <= '0;
      r_c_base <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner  <= w_winner;
            r_a_base <= req_a_base[w_winner];
            r_b_base <= req_b_base[w_winner];
            r_c_base <= req_c_base[w_winner];
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_timer <= '0;
          r_err   <= 1'b0;
        end
        S_RUN: begin
          if (eng_res_write_en && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
          r_timer <= r_timer + TMR_W'(1);
          // Done takes priority over a timeout in the same cycle.
          if (eng_exec_done)  r_err <= !w_count_ok;
          else if (w_timeout) r_err <= 1'b1;
        end
        S_RESP: begin
          if (w_rsp_hs) r_ptr <= rr_idx(r_owner, 1);
        end
        default: ;
      endcase
    end
  end

  assign rsp_err    = r_err && (r_state == S_RESP);
  assign eng_a_base = r_a_base;
  assign eng_b_base = r_b_base;
  assign eng_c_base = r_c_base;
  assign owner_id   = r_owner;

endmodule

// File: tb/tb_matmul_job_sched.sv
// Directed bench for matmul_job_sched: a table of job scenarios with hand-computed
// grants and error flags, plus a reset-during-RUN sequence.
module tb_matmul_job_sched;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int ADDR_W  = 16;
  localparam int DIM     = 3;
  localparam int TO      = 80;

  localparam int M_COINC  = 0;  // done together with the last write
  localparam int M_LATE   = 1;  // done one cycle after the last write
  localparam int M_NODONE = 2;  // never done: timeout
  localparam int M_AT_TO  = 3;  // done exactly in the timeout cycle

  typedef struct {
    logic [3:0] mask;
    int         n_wr;
    int         mode;
    int         bp;
    int         owner;
    bit         err;
    bit         abort;
  } vec_t;

  logic                           clk;
  logic                           rst;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_a_base;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_b_base;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_c_base;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [NUM_REQ-1:0]             rsp_ready;
  logic                           rsp_err;
  logic                           eng_start;
  logic                           eng_abort;
  logic [ADDR_W-1:0]              eng_a_base;
  logic [ADDR_W-1:0]              eng_b_base;
  logic [ADDR_W-1:0]              eng_c_base;
  logic                           eng_res_write_en;
  logic                           eng_exec_done;
  logic                           busy;
  logic [ID_W-1:0]                owner_id;

  logic [ADDR_W-1:0] lane_a [NUM_REQ];
  logic [ADDR_W-1:0] lane_b [NUM_REQ];
  logic [ADDR_W-1:0] lane_c [NUM_REQ];

  int   n_checks;
  int   n_fail;
  vec_t vecs [17];

  matmul_job_sched #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W),
    .DIM_INDEX_WIDTH(DIM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a_base(req_a_base), .req_b_base(req_b_base), .req_c_base(req_c_base),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_abort(eng_abort),
    .eng_a_base(eng_a_base), .eng_b_base(eng_b_base), .eng_c_base(eng_c_base),
    .eng_res_write_en(eng_res_write_en), .eng_exec_done(eng_exec_done),
    .busy(busy), .owner_id(owner_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_job(input vec_t v, input int id);
    logic [3:0] oh;
    int         aborts;
    int         abort_cyc;
    int         bp_bad;
    oh        = 4'(1 << v.owner);
    aborts    = 0;
    abort_cyc = 0;
    bp_bad    = 0;

    req_valid = v.mask;
    #1;
    check($sformatf("v%0d req_ready", id), 32'(req_ready), 32'(oh));

    @(negedge clk); #1;
    check($sformatf("v%0d eng_start", id), 32'(eng_start), 32'd1);
    check($sformatf("v%0d owner_id", id), 32'(owner_id), 32'(v.owner));
    check($sformatf("v%0d eng_a_base", id), 32'(eng_a_base), 32'(lane_a[v.owner]));
    check($sformatf("v%0d eng_b_base", id), 32'(eng_b_base), 32'(lane_b[v.owner]));
    check($sformatf("v%0d eng_c_base", id), 32'(eng_c_base), 32'(lane_c[v.owner]));
    check($sformatf("v%0d busy_start", id), 32'(busy), 32'd1);

    for (int cyc = 1; cyc <= TO; cyc++) begin
      @(negedge clk);
      eng_res_write_en = (cyc <= v.n_wr);
      eng_exec_done    = (v.mode == M_COINC && cyc == v.n_wr) ||
                         (v.mode == M_LATE  && cyc == v.n_wr + 1) ||
                         (v.mode == M_AT_TO && cyc == TO);
      #1;
      if (eng_abort) begin
        aborts++;
        abort_cyc = cyc;
      end
      if (eng_exec_done) break;
    end
    check($sformatf("v%0d abort_count", id), 32'(aborts), 32'(v.abort));
    check($sformatf("v%0d abort_cycle", id), 32'(abort_cyc), v.abort ? 32'(TO) : 32'd0);

    @(negedge clk);
    eng_res_write_en = 1'b0;
    eng_exec_done    = 1'b0;
    #1;
    check($sformatf("v%0d rsp_valid", id), 32'(rsp_valid), 32'(oh));
    check($sformatf("v%0d rsp_err", id), 32'(rsp_err), 32'(v.err));

    // Held response; non-owner ready and stray engine strobes must be ignored.
    for (int i = 0; i < v.bp; i++) begin
      rsp_ready        = ~oh;
      eng_res_write_en = 1'b1;
      eng_exec_done    = 1'b1;
      @(negedge clk); #1;
      if (rsp_valid !== oh || rsp_err !== v.err || req_ready !== 4'd0 || eng_start !== 1'b0)
        bp_bad++;
    end
    if (v.bp > 0) check($sformatf("v%0d backpressure_hold", id), 32'(bp_bad), 32'd0);

    rsp_ready        = oh;
    eng_res_write_en = 1'b0;
    eng_exec_done    = 1'b0;
    #1;
    check($sformatf("v%0d no_regrant_in_hs", id), 32'(req_ready), 32'd0);
    @(negedge clk);
    rsp_ready = '0;
    #1;
    check($sformatf("v%0d busy_after", id), 32'(busy), 32'd0);
    check($sformatf("v%0d rsp_valid_after", id), 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, 32'(req_ready), 32'd0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, " eng_start"}, 32'(eng_start), 32'd0);
    check({tag, " eng_abort"}, 32'(eng_abort), 32'd0);
    check({tag, " eng_bases"}, {eng_a_base, eng_b_base} | 32'(eng_c_base), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " owner_id"}, 32'(owner_id), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    lane_a = '{16'h0A00, 16'h1A00, 16'h0100, 16'h3A00};
    lane_b = '{16'h0B00, 16'h1B00, 16'h0200, 16'h3B00};
    lane_c = '{16'h0C00, 16'h1C00, 16'h0300, 16'h3C00};
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a_base[i] = lane_a[i];
      req_b_base[i] = lane_b[i];
      req_c_base[i] = lane_c[i];
    end

    //          mask   n_wr mode      bp  owner err   abort
    vecs[0]  = '{4'hF, 64, M_COINC,  0,  0, 1'b0, 1'b0};
    vecs[1]  = '{4'hF, 64, M_COINC,  0,  1, 1'b0, 1'b0};
    vecs[2]  = '{4'hF, 64, M_LATE,   0,  2, 1'b0, 1'b0};
    vecs[3]  = '{4'hF, 64, M_COINC,  0,  3, 1'b0, 1'b0};
    vecs[4]  = '{4'hF, 64, M_COINC,  0,  0, 1'b0, 1'b0};
    vecs[5]  = '{4'hA, 64, M_COINC,  0,  1, 1'b0, 1'b0};
    vecs[6]  = '{4'hA, 64, M_COINC,  0,  3, 1'b0, 1'b0};
    vecs[7]  = '{4'hA, 64, M_COINC,  0,  1, 1'b0, 1'b0};
    vecs[8]  = '{4'h4, 64, M_COINC,  0,  2, 1'b0, 1'b0};
    vecs[9]  = '{4'h1, 63, M_COINC,  0,  0, 1'b1, 1'b0};
    vecs[10] = '{4'h1, 65, M_COINC,  0,  0, 1'b1, 1'b0};
    vecs[11] = '{4'h2,  5, M_NODONE, 0,  1, 1'b1, 1'b1};
    vecs[12] = '{4'h8, 64, M_AT_TO,  0,  3, 1'b0, 1'b0};
    vecs[13] = '{4'h8, 10, M_AT_TO,  0,  3, 1'b1, 1'b0};
    vecs[14] = '{4'h9, 64, M_COINC, 10,  0, 1'b0, 1'b0};
    vecs[15] = '{4'h8, 64, M_COINC,  0,  3, 1'b0, 1'b0};
    vecs[16] = '{4'h2, 64, M_COINC,  0,  1, 1'b0, 1'b0};

    rst              = 1'b1;
    req_valid        = '0;
    rsp_ready        = '0;
    eng_res_write_en = 1'b0;
    eng_exec_done    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) run_job(vecs[i], i);

    // Reset in the middle of a RUN after 20 writes; pointer is 2 at this point.
    req_valid = 4'h4;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      eng_res_write_en = 1'b1;
    end
    @(negedge clk);
    eng_res_write_en = 1'b0;
    #1;
    check("mid_run owner_id", 32'(owner_id), 32'd2);
    check("mid_run busy", 32'(busy), 32'd1);
    #1;
    rst       = 1'b1;
    req_valid = '0;
    #1;
    check_reset_outputs("mid_run_rst");
    @(negedge clk);
    rst = 1'b0;
    run_job('{4'hF, 64, M_COINC, 0, 0, 1'b0, 1'b0}, 17);

    req_valid = '0;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_job_sched.md
Name: matmul_job_sched

Overview:
- Shares one matmul engine between NUM_REQ requesters (host DMA, tiling sequencer, etc.). Each requester supplies a job descriptor: A, B and C base addresses.
- Round-robin arbitration picks one job at a time. The block loads the descriptor into the engine address registers, pulses the engine start, and monitors engine result writes and completion.
- It returns a per-requester completion response with an error flag. Sits between requesters and the engine/memory-address muxing.

Parameters:
- NUM_REQ, 4, number of requesters
- ID_W, 2, requester index width (clog2(NUM_REQ))
- ADDR_W, 16, descriptor base address width
- DIM_INDEX_WIDTH, 3, engine dimension index width; expected writes per job = 2**(2*DIM_INDEX_WIDTH)
- TIMEOUT_CYCLES, 4095, max RUN cycles before abort (>= 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NUM_REQ  job request per requester
- req_ready  out  NUM_REQ  job accepted (one-hot or zero)
- req_a_base  in  NUM_REQ x ADDR_W  A base per requester
- req_b_base  in  NUM_REQ x ADDR_W  B base per requester
- req_c_base  in  NUM_REQ x ADDR_W  C base per requester
- rsp_valid  out  NUM_REQ  completion response, one-hot or zero
- rsp_ready  in  NUM_REQ  response accepted
- rsp_err  out  1  error flag, qualified by any rsp_valid
- eng_start  out  1  one-cycle engine start pulse
- eng_abort  out  1  one-cycle engine abort pulse on timeout
- eng_a_base / eng_b_base / eng_c_base  out  ADDR_W each  active job descriptor
- eng_res_write_en  in  1  engine result write strobe
- eng_exec_done  in  1  engine completion pulse
- busy  out  1  high in any state except IDLE
- owner_id  out  ID_W  index of current/last granted requester

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
- All outputs 0 after reset: req_ready, rsp_valid, rsp_err, eng_start, eng_abort, eng_*_base, busy, owner_id. State IDLE; RR pointer 0; write count 0; timer 0.

State machine (IDLE -> START -> RUN -> RESP -> IDLE):
- IDLE:
  - Winner = first i with req_valid[i], searching from pointer upward with wrap modulo NUM_REQ.
  - req_ready[winner] = 1 combinationally in the same cycle; all other req_ready bits are 0.
  - On acceptance, register the winner's descriptor into eng_*_base and the winner into owner_id, then go to START.
  - No req_valid: remain in IDLE.
- START:
  - eng_start = 1 for exactly this cycle.
  - Clear write count and timer; go to RUN.
  - Acceptance in cycle T gives eng_start in T+1.
- RUN:
  - Each cycle with eng_res_write_en high increments the write count. The count is 2*DIM_INDEX_WIDTH+1 bits and saturates at all-ones.
  - On eng_exec_done: rsp_err = 1 unless (count + eng_res_write_en in that same cycle) == 2**(2*DIM_INDEX_WIDTH). Go to RESP.
  - The last write and done may coincide; the coincident write is counted.
  - Timer increments every RUN cycle. When timer == TIMEOUT_CYCLES-1 and eng_exec_done is low: eng_abort = 1 for one cycle, rsp_err = 1, go to RESP.
  - If done and timeout fall in the same cycle, done wins and no abort is issued.
- RESP:
  - rsp_valid[owner_id] = 1 and rsp_err held stable until rsp_ready[owner_id].
  - On handshake: pointer = (owner_id+1) mod NUM_REQ, go to IDLE. The next arbitration happens in the following cycle; there is no same-cycle re-grant.
  - rsp_ready on non-owner lines is ignored.
- eng_res_write_en and eng_exec_done outside RUN are ignored.
- req_valid may drop before acceptance without penalty.
- eng_*_base and owner_id hold their values until the next acceptance.
- busy = (state != IDLE).
- Reset mid-operation (any state) returns everything to reset values immediately. It asserts no eng_abort and no response.

Test Plan:
- Single job: req_valid[2]=1, bases A=0x0100, B=0x0200, C=0x0300 -> req_ready[2] in the same cycle; eng_start 1 cycle later with bases driven. Drive 64 writes with exec_done on the 64th -> rsp_valid[2]=1, rsp_err=0. On rsp_ready[2], busy falls.
- Round-robin contention: all four req_valid held high, each job completing cleanly -> grant order 0,1,2,3,0. Then with only req 1 and req 3 high, from pointer 1 -> order 1,3,1.
- Write-count mismatch: 63 writes then exec_done -> rsp_err=1. Separately, 65 writes -> rsp_err=1.
- Timeout: TIMEOUT_CYCLES=16, no exec_done -> eng_abort pulse at the 16th RUN cycle; rsp_valid[owner]=1, rsp_err=1. Done arriving in that exact cycle -> no abort, rsp_err reflects the write count.
- Response backpressure: rsp_ready low for 10 cycles with another req_valid pending -> rsp_valid held, no req_ready, no eng_start. After the handshake, the pending requester is granted 1 cycle later.
- Reset in RUN after 20 writes -> all outputs 0, busy=0. A new request then grants requester 0 first (pointer reset) and counts writes from 0.
